// File: rtl/grf_pkg.sv
// Shared constants and helpers for the grf_sb register file.
// Default geometry, the hard-wired zero register index and a
// constant-evaluable ceil(log2) used to size address and count fields.
package grf_pkg;

  localparam int GRF_DW   = 32;
  localparam int GRF_NREG = 32;
  localparam int GRF_NRD  = 2;
  localparam int GRF_NWR  = 2;
  localparam int GRF_CW   = 2;

  localparam int ZERO_REG = 0;

  // Number of bits needed to encode 'value' distinct states.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 32'sd1;
    r = 32'sd0;
    while (v > 32'sd0) begin
      r = r + 32'sd1;
      v = v >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/grf_sb_if.sv
// Bus bundle between the decode/writeback stages and the register file.
// master = pipeline side, slave = register file side.
interface grf_sb_if
  import grf_pkg::*;
#(
  parameter int DW   = GRF_DW,
  parameter int NREG = GRF_NREG,
  parameter int NRD  = GRF_NRD,
  parameter int NWR  = GRF_NWR
) ();

  localparam int AW = clog2(NREG);

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NWR-1:0]    wr_clr;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic              iss_ready;
  logic [NWR*32-1:0] pc;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr, pc,
    input  rd_data, rd_busy, iss_ready
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr, pc,
    output rd_data, rd_busy, iss_ready
  );

endinterface

// File: rtl/grf_sb_cnt.sv
// One scoreboard entry: counts in-flight producers of a register.
// Adds one on an accepted issue, subtracts the number of clearing writes,
// and clamps to [0, 2^CW-1] so a stray writeback can never wrap it.
module grf_sb_cnt
  import grf_pkg::*;
#(
  parameter int CW = GRF_CW,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc_i,
  input  logic [KW-1:0] dec_i,
  output logic          busy_o,
  output logic          full_o
);

  localparam int SW = ((CW > KW) ? CW : KW) + 1;
  localparam logic [SW-1:0] MAX_S = SW'((1 << CW) - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [SW-1:0] up_s;
  logic [SW-1:0] dec_s;

  assign up_s  = SW'(cnt_q) + SW'(inc_i);
  assign dec_s = SW'(dec_i);

  // Producers still outstanding after this cycle's retirements.
  assign busy_o = (SW'(cnt_q) > dec_s);
  // Full only when nothing retires this cycle to make room.
  assign full_o = (SW'(cnt_q) == MAX_S) && (dec_i == KW'(0));

  // Next count: combine issue and retirements, clamp at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (up_s <= dec_s) begin
      cnt_d = '0;
    end else if ((up_s - dec_s) > MAX_S) begin
      cnt_d = MAX_S[CW-1:0];
    end else begin
      cnt_d = CW'(up_s - dec_s);
    end
  end

  // Counter register, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/grf_sb.sv
// Parametrised register file with same-cycle write bypass, a hard-wired
// zero register and a per-register pending-write scoreboard.
// Optional build macro GRF_TRACE_EN: prints every committed write.
module grf_sb
  import grf_pkg::*;
#(
  parameter int DW   = GRF_DW,
  parameter int NREG = GRF_NREG,
  parameter int NRD  = GRF_NRD,
  parameter int NWR  = GRF_NWR,
  parameter int CW   = GRF_CW
) (
  input  logic     clk,
  input  logic     reset_n,
  grf_sb_if.slave  bus
);

  localparam int AW = clog2(NREG);
  localparam int KW = clog2(NWR + 1);

  logic [DW-1:0]     regs_q [NREG];
  logic [DW-1:0]     regs_d [NREG];
  logic [KW-1:0]     clr_cnt_s [1:NREG-1];
  logic [NREG-1:0]   busy_s;
  logic [NREG-1:0]   full_s;
  logic              iss_ready_s;
  logic [AW-1:0]     ra_s [NRD];
  logic [DW-1:0]     rv_s [NRD];
  logic [NRD*DW-1:0] rd_data_s;
  logic [NRD-1:0]    rd_busy_s;

  assign busy_s[0] = 1'b0;
  assign full_s[0] = 1'b0;

  // Number of clearing writes aimed at each register this cycle.
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      clr_cnt_s[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        clr_cnt_s[r] = clr_cnt_s[r] + KW'(bus.wr_en[j] && bus.wr_clr[j] &&
                                          (bus.wr_addr[j*AW +: AW] == AW'(r)));
      end
    end
  end

  // Issue is blocked only when the destination counter is full.
  assign iss_ready_s = (bus.iss_addr == AW'(ZERO_REG)) || !full_s[bus.iss_addr];
  assign bus.iss_ready = !reset_n || iss_ready_s;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic inc_s;
    assign inc_s = bus.iss_en && iss_ready_s && (bus.iss_addr == AW'(r));

    grf_sb_cnt #(
      .CW (CW),
      .KW (KW)
    ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_i   (inc_s),
      .dec_i   (clr_cnt_s[r]),
      .busy_o  (busy_s[r]),
      .full_o  (full_s[r])
    );
  end

  // Next register contents: later ports override earlier ones on a clash.
  always_comb begin
    regs_d = regs_q;
    for (int r = 1; r < NREG; r++) begin
      for (int j = 0; j < NWR; j++) begin
        regs_d[r] = (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == AW'(r)))
                    ? bus.wr_data[j*DW +: DW] : regs_d[r];
      end
    end
    regs_d[ZERO_REG] = '0;
  end

  // Register array, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: stored value, replaced by the highest-index matching write.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      ra_s[i] = bus.rd_addr[i*AW +: AW];
      rv_s[i] = regs_q[ra_s[i]];
      for (int j = 0; j < NWR; j++) begin
        rv_s[i] = (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == ra_s[i]))
                  ? bus.wr_data[j*DW +: DW] : rv_s[i];
      end
    end
  end

  // Zero register and reset force data and busy low.
  always_comb begin
    rd_data_s = '0;
    rd_busy_s = '0;
    for (int i = 0; i < NRD; i++) begin
      if (!reset_n || (ra_s[i] == AW'(ZERO_REG))) begin
        rd_data_s[i*DW +: DW] = '0;
        rd_busy_s[i]          = 1'b0;
      end else begin
        rd_data_s[i*DW +: DW] = rv_s[i];
        rd_busy_s[i]          = busy_s[ra_s[i]];
      end
    end
  end

  assign bus.rd_data = rd_data_s;
  assign bus.rd_busy = rd_busy_s;

`ifdef GRF_TRACE_EN
  // Log every retired write, same-address losers included, lowest port first.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NWR; j++) begin
      if (reset_n && bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
        $display("@%h: $%d <= %h", bus.pc[j*32 +: 32], bus.wr_addr[j*AW +: AW],
                 bus.wr_data[j*DW +: DW]);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_grf_sb.sv
// Self-checking bench for grf_sb: directed scenarios plus randomized traffic
// against an array/integer reference model of the register file and scoreboard.
module tb_grf_sb;
  import grf_pkg::*;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int CW   = 2;
  localparam int AW   = clog2(NREG);
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  logic [DW-1:0] m_reg [NREG];
  int            m_cnt [NREG];

  grf_sb_if #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  grf_sb #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r] = '0;
      m_cnt[r] = 0;
    end
  endtask

  function automatic int k_of(input int a);
    int k = 0;
    for (int j = 0; j < NWR; j++)
      if (bus.wr_en[j] && bus.wr_clr[j] && int'(bus.wr_addr[j*AW +: AW]) == a) k++;
    return k;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int a);
    if (a == 0) return '0;
    for (int j = NWR - 1; j >= 0; j--)
      if (bus.wr_en[j] && int'(bus.wr_addr[j*AW +: AW]) == a) return bus.wr_data[j*DW +: DW];
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input int a);
    if (a == 0) return 1'b0;
    return (m_cnt[a] - k_of(a)) > 0;
  endfunction

  function automatic logic exp_ready();
    int a = int'(bus.iss_addr);
    if (a == 0) return 1'b1;
    return (m_cnt[a] != CMAX) || (k_of(a) > 0);
  endfunction

  // Advance one clock: commit the model from the pre-edge inputs.
  task automatic step();
    int  nc [NREG];
    bit  acc;
    acc = bus.iss_en && exp_ready();
    for (int r = 0; r < NREG; r++) begin
      nc[r] = m_cnt[r] - k_of(r);
      if (acc && int'(bus.iss_addr) == r) nc[r] = nc[r] + 1;
      if (nc[r] < 0) nc[r] = 0;
      if (nc[r] > CMAX) nc[r] = CMAX;
      if (r == 0) nc[r] = 0;
    end
    for (int j = 0; j < NWR; j++)
      if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
        m_reg[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*DW +: DW];
    m_cnt = nc;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_clr   = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.pc       = '0;
  endtask

  task automatic set_wr(input int j, input bit en, input bit clr, input int a,
                        input logic [DW-1:0] d);
    bus.wr_en[j]              = en;
    bus.wr_clr[j]             = clr;
    bus.wr_addr[j*AW +: AW]   = AW'(a);
    bus.wr_data[j*DW +: DW]   = d;
    bus.pc[j*32 +: 32]        = 32'h0000_1000 + 32'(j * 4);
  endtask

  task automatic set_rd(input int i, input int a);
    bus.rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic set_iss(input bit en, input int a);
    bus.iss_en   = en;
    bus.iss_addr = AW'(a);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_idle();
    set_wr(0, 1'b1, 1'b0, 3, 32'hCAFE_F00D);
    set_rd(0, 3);
    set_iss(1'b0, 3);
    #3;
    n_checks++;
    if (bus.rd_data[0 +: DW] !== 32'h0) $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data[0 +: DW]);
    else n_pass++;
    n_checks++;
    if (bus.rd_busy !== 2'b00) $display("FAIL reset_rd_busy got=%b exp=00", bus.rd_busy);
    else n_pass++;
    n_checks++;
    if (bus.iss_ready !== 1'b1) $display("FAIL reset_iss_ready got=%b exp=1", bus.iss_ready);
    else n_pass++;
    set_idle();
    reset_n = 1'b1;
    model_reset();
    step();
    set_rd(0, 3);
    #2;
    n_checks++;
    if (bus.rd_data[0 +: DW] !== 32'h0) $display("FAIL reset_write_ignored got=%h exp=0", bus.rd_data[0 +: DW]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    set_idle();
    set_wr(0, 1'b1, 1'b0, 3, 32'h1234_5678);
    set_rd(1, 3);
    #2;
    n_checks++;
    if (bus.rd_data[DW +: DW] !== 32'h1234_5678) $display("FAIL bypass_same_cycle got=%h exp=12345678", bus.rd_data[DW +: DW]);
    else n_pass++;
    step();
    set_idle();
    set_rd(1, 3);
    #2;
    n_checks++;
    if (bus.rd_data[DW +: DW] !== 32'h1234_5678) $display("FAIL bypass_stored got=%h exp=12345678", bus.rd_data[DW +: DW]);
    else n_pass++;
    step();
  endtask

  task automatic test_priority();
    set_idle();
    set_wr(0, 1'b1, 1'b0, 7, 32'h0000_1111);
    set_wr(1, 1'b1, 1'b0, 7, 32'h0000_2222);
    set_rd(0, 7);
    #2;
    n_checks++;
    if (bus.rd_data[0 +: DW] !== 32'h0000_2222) $display("FAIL prio_same_cycle got=%h exp=00002222", bus.rd_data[0 +: DW]);
    else n_pass++;
    step();
    set_idle();
    set_wr(0, 1'b1, 1'b0, 0, 32'hFFFF_FFFF);
    set_rd(0, 0);
    set_rd(1, 7);
    #2;
    n_checks++;
    if (bus.rd_data[0 +: DW] !== 32'h0) $display("FAIL r0_bypass got=%h exp=0", bus.rd_data[0 +: DW]);
    else n_pass++;
    n_checks++;
    if (bus.rd_data[DW +: DW] !== 32'h0000_2222) $display("FAIL prio_stored got=%h exp=00002222", bus.rd_data[DW +: DW]);
    else n_pass++;
    step();
    set_idle();
    set_rd(0, 0);
    #2;
    n_checks++;
    if (bus.rd_data[0 +: DW] !== 32'h0) $display("FAIL r0_stored got=%h exp=0", bus.rd_data[0 +: DW]);
    else n_pass++;
  endtask

  task automatic test_stall();
    set_idle();
    set_iss(1'b1, 9);
    #2;
    n_checks++;
    if (bus.iss_ready !== 1'b1) $display("FAIL stall_issue_ready got=%b exp=1", bus.iss_ready);
    else n_pass++;
    step();
    for (int c = 0; c < 2; c++) begin
      set_idle();
      set_rd(0, 9);
      #2;
      n_checks++;
      if (bus.rd_busy[0] !== 1'b1) $display("FAIL stall_busy_idle%0d got=%b exp=1", c, bus.rd_busy[0]);
      else n_pass++;
      step();
    end
    set_idle();
    set_rd(0, 9);
    set_wr(1, 1'b1, 1'b1, 9, 32'h0000_00AB);
    #2;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0) $display("FAIL stall_lift got=%b exp=0", bus.rd_busy[0]);
    else n_pass++;
    n_checks++;
    if (bus.rd_data[0 +: DW] !== 32'h0000_00AB) $display("FAIL stall_lift_data got=%h exp=000000ab", bus.rd_data[0 +: DW]);
    else n_pass++;
    step();
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 3; c++) begin
      set_idle();
      set_iss(1'b1, 4);
      #2;
      n_checks++;
      if (bus.iss_ready !== 1'b1) $display("FAIL sat_issue%0d got=%b exp=1", c, bus.iss_ready);
      else n_pass++;
      step();
    end
    set_idle();
    set_iss(1'b1, 4);
    #2;
    n_checks++;
    if (bus.iss_ready !== 1'b0) $display("FAIL sat_full got=%b exp=0", bus.iss_ready);
    else n_pass++;
    step();
    set_idle();
    set_iss(1'b1, 4);
    set_wr(0, 1'b1, 1'b1, 4, 32'h0000_0044);
    #2;
    n_checks++;
    if (bus.iss_ready !== 1'b1) $display("FAIL sat_issue_with_clear got=%b exp=1", bus.iss_ready);
    else n_pass++;
    step();
    set_idle();
    set_iss(1'b0, 4);
    set_rd(0, 4);
    #2;
    n_checks++;
    if (bus.iss_ready !== 1'b0) $display("FAIL sat_still3 got=%b exp=0", bus.iss_ready);
    else n_pass++;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b1) $display("FAIL sat_busy got=%b exp=1", bus.rd_busy[0]);
    else n_pass++;
    set_wr(0, 1'b1, 1'b1, 4, 32'h0000_0045);
    set_wr(1, 1'b1, 1'b1, 4, 32'h0000_0046);
    step();
    set_idle();
    set_rd(0, 4);
    #2;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b1) $display("FAIL sat_drain2 got=%b exp=1", bus.rd_busy[0]);
    else n_pass++;
    set_wr(0, 1'b1, 1'b1, 4, 32'h0000_0047);
    step();
    set_idle();
    set_rd(0, 4);
    #2;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[0 +: DW] !== 32'h0000_0047)
      $display("FAIL sat_drained got=%b/%h exp=0/00000047", bus.rd_busy[0], bus.rd_data[0 +: DW]);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    set_idle();
    set_iss(1'b1, 6);
    step();
    set_idle();
    set_iss(1'b1, 6);
    set_wr(0, 1'b1, 1'b1, 6, 32'h0000_0606);
    set_rd(1, 6);
    #2;
    n_checks++;
    if (bus.rd_busy[1] !== 1'b0) $display("FAIL simul_busy_now got=%b exp=0", bus.rd_busy[1]);
    else n_pass++;
    step();
    set_idle();
    set_rd(1, 6);
    #2;
    n_checks++;
    if (bus.rd_busy[1] !== 1'b1) $display("FAIL simul_busy_next got=%b exp=1", bus.rd_busy[1]);
    else n_pass++;
    set_wr(0, 1'b1, 1'b1, 6, 32'h0000_0607);
    step();
    set_idle();
    set_wr(1, 1'b1, 1'b1, 6, 32'h0000_0608);
    step();
    set_idle();
    set_iss(1'b0, 6);
    set_rd(1, 6);
    #2;
    n_checks++;
    if (bus.iss_ready !== 1'b1 || bus.rd_busy[1] !== 1'b0)
      $display("FAIL clamp_zero got ready=%b busy=%b exp ready=1 busy=0", bus.iss_ready, bus.rd_busy[1]);
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    set_idle();
    set_wr(0, 1'b1, 1'b0, 5, 32'hDEAD_BEEF);
    step();
    for (int c = 0; c < 2; c++) begin
      set_idle();
      set_iss(1'b1, 5);
      step();
    end
    set_idle();
    set_rd(0, 5);
    set_iss(1'b0, 5);
    #2;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b1 || bus.rd_data[0 +: DW] !== 32'hDEAD_BEEF)
      $display("FAIL midrun_pre got=%b/%h exp=1/deadbeef", bus.rd_busy[0], bus.rd_data[0 +: DW]);
    else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.rd_data[0 +: DW] !== 32'h0 || bus.rd_busy[0] !== 1'b0 || bus.iss_ready !== 1'b1)
      $display("FAIL midrun_in_reset got=%h/%b/%b exp=0/0/1", bus.rd_data[0 +: DW], bus.rd_busy[0], bus.iss_ready);
    else n_pass++;
    #2;
    reset_n = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (bus.rd_data[0 +: DW] !== 32'h0 || bus.rd_busy[0] !== 1'b0)
      $display("FAIL midrun_after got=%h/%b exp=0/0", bus.rd_data[0 +: DW], bus.rd_busy[0]);
    else n_pass++;
    set_wr(1, 1'b1, 1'b1, 5, 32'h0000_0555);
    step();
    set_idle();
    set_rd(0, 5);
    set_iss(1'b0, 5);
    #2;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.iss_ready !== 1'b1 || bus.rd_data[0 +: DW] !== 32'h0000_0555)
      $display("FAIL midrun_late_wb got=%b/%b/%h exp=0/1/00000555", bus.rd_busy[0], bus.iss_ready, bus.rd_data[0 +: DW]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_idle();
      for (int i = 0; i < NRD; i++) set_rd(i, int'($urandom_range(0, 7)));
      for (int j = 0; j < NWR; j++)
        set_wr(j, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), DW'($urandom));
      set_iss(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
      #2;
      for (int i = 0; i < NRD; i++) begin
        n_checks++;
        if (bus.rd_data[i*DW +: DW] !== exp_rd(int'(bus.rd_addr[i*AW +: AW])))
          $display("FAIL rnd_rd_data c=%0d p=%0d got=%h exp=%h", c, i, bus.rd_data[i*DW +: DW],
                   exp_rd(int'(bus.rd_addr[i*AW +: AW])));
        else n_pass++;
        n_checks++;
        if (bus.rd_busy[i] !== exp_busy(int'(bus.rd_addr[i*AW +: AW])))
          $display("FAIL rnd_rd_busy c=%0d p=%0d got=%b exp=%b", c, i, bus.rd_busy[i],
                   exp_busy(int'(bus.rd_addr[i*AW +: AW])));
        else n_pass++;
      end
      n_checks++;
      if (bus.iss_ready !== exp_ready())
        $display("FAIL rnd_iss_ready c=%0d got=%b exp=%b", c, bus.iss_ready, exp_ready());
      else n_pass++;
      step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_bypass();
    test_priority();
    test_stall();
    test_saturation();
    test_simultaneous();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
